cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter: BLOCK_WORDS, 8, 16-bit words per cache line (only 8 supported; 16-byte line).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: miss_detected  input  1  cache reports miss this cycle (cache hit=0 with access pending).
REQ-005 SHALL have port: miss_address  input  16  byte address of the missing access.
REQ-006 SHALL have port: memory_data  input  16  word returned by main memory.
REQ-007 SHALL have port: memory_data_valid  input  1  memory_data is valid this cycle.
REQ-008 SHALL have port: fsm_busy  output  1  fill in progress; pipeline stalls.
REQ-009 SHALL have port: memory_read_en  output  1  issue read of memory_address this cycle.
REQ-010 SHALL have port: memory_address  output  16  word address requested from memory.
REQ-011 SHALL have port: cache_addr  output  16  address driven to the cache's addr input during fill.
REQ-012 SHALL have port: data_out  output  16  word to cache data_in.
REQ-013 SHALL have port: write_data_array  output  1  cache data-array write enable.
REQ-014 SHALL have port: tag_out  output  8  tag to cache tag_in.
REQ-015 SHALL have port: write_tag_array  output  1  cache tag-array write enable.

Function
REQ-016 SHALL implement two states, IDLE and FILL, plus a 4-bit request counter req_cnt and a 4-bit receive counter rcv_cnt.
REQ-017 In IDLE with miss_detected=1, SHALL latch miss_address[15:4] as line base, clear both counters, and enter FILL next cycle.
REQ-018 fsm_busy SHALL equal (state==FILL) | (state==IDLE & miss_detected), i.e. asserted combinationally in the miss cycle.
REQ-019 In FILL, memory_read_en SHALL be 1 while req_cnt<8; each asserted cycle increments req_cnt; exactly 8 requests per fill, one per cycle, no gaps.
REQ-020 memory_address SHALL be {base, req_cnt[2:0], 1'b0}; word 0 first, sequential; 0 when memory_read_en=0.
REQ-021 In FILL, each cycle with memory_data_valid=1 SHALL assert write_data_array, drive data_out=memory_data, cache_addr={base, rcv_cnt[2:0], 1'b0}, and increment rcv_cnt.
REQ-022 FSM SHALL be memory-latency independent; responses assumed in request order, at most one per cycle.
REQ-023 On the cycle the 8th word is written (rcv_cnt==7 & valid), write_tag_array SHALL also be 1 with tag_out={base[15:10], 1'b1, 1'b0}; next state IDLE.
REQ-024 tag_out bit1 is the valid bit; bit0 (LRU) is driven 0 and maintained by the cache's metadata array.
REQ-025 In IDLE, write_data_array, write_tag_array, memory_read_en SHALL be 0; memory_data_valid SHALL be ignored.
REQ-026 miss_detected during FILL SHALL be ignored; no re-latch of base.
REQ-027 cache_addr SHALL equal miss_address when state==IDLE, else the fill address per REQ-021.
REQ-028 Counter wrap: req_cnt saturates at 8; rcv_cnt never exceeds 7 in FILL.
REQ-029 With BLOCK_WORDS=8 and 4-cycle memory latency, miss at cycle 0 SHALL yield requests cycles 1-8, writes cycles 5-12, tag write cycle 12, fsm_busy=0 from cycle 13.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force IDLE, counters=0, base=0, all registered outputs 0.
REQ-031 rst mid-FILL SHALL abandon the fill without tag write; memory responses arriving after reset are ignored (REQ-025).

Structure
REQ-032 State enum, BLOCK_WORDS, and tag field positions (tag [7:2], valid [1], LRU [0]) SHALL live in shared package cache_pkg.
REQ-033 One sub-module, fill_counter (4-bit, async reset, clear, enable, saturate-at-8), SHALL be instantiated twice for req_cnt and rcv_cnt.

Verification
REQ-034 Miss at 0x1A36, latency 4 -> addresses 0x1A30..0x1A3E cycles 1-8, 8 data writes, tag_out=0x1A at cycle 12, idle cycle 13.
REQ-035 Latency 1 memory -> writes cycles 2-9 overlap requests; tag write with 8th word; exactly 8 writes.
REQ-036 memory_data_valid with bubbles (valid every other cycle) -> rcv_cnt only advances on valid; tag write only after 8th valid.
REQ-037 miss_detected held high throughout FILL with changing miss_address -> base unchanged, single fill, no extra requests.
REQ-038 rst asserted at cycle 6 of fill, then valid pulses -> outputs 0 at once, no write_tag_array, no writes while IDLE.
REQ-039 Back-to-back misses (new miss cycle 13) -> second fill starts cycle 14 with new base, fsm_busy high in cycle 13.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache line-fill logic.
//   BLOCK_WORDS   : 16-bit words per cache line (16-byte line)
//   fill_state_t  : fill controller states (IDLE, FILL)
//   TAG_*         : bit positions inside the 8-bit tag-array entry
//                   tag [7:2], valid [1], LRU [0]
//   make_tag()    : builds a freshly-filled tag entry (valid set, LRU clear)
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int BLOCK_WORDS   = 8;

   localparam int TAG_MSB       = 7;
   localparam int TAG_LSB       = 2;
   localparam int TAG_VALID_BIT = 1;
   localparam int TAG_LRU_BIT   = 0;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   // LRU is left at 0 here; the cache's metadata array owns that bit.
   function automatic logic [7:0] make_tag(input logic [TAG_MSB-TAG_LSB:0] tag_bits);
      logic [7:0] entry;
      entry                   = '0;
      entry[TAG_MSB:TAG_LSB]  = tag_bits;
      entry[TAG_VALID_BIT]    = 1'b1;
      entry[TAG_LRU_BIT]      = 1'b0;
      return entry;
   endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// -----------------------------------------------------------------------------
// fill_counter
// Small up-counter used to track word requests and word receipts during a
// cache line fill. Saturates at MAX so it can never wrap past the line end.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, count -> 0
//   clear   : synchronous clear (has priority over enable)
//   enable  : count up by one this cycle (ignored once count == MAX)
//   count   : current count value
// -----------------------------------------------------------------------------
module fill_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MAX);

   // Clear wins over enable so a new fill always starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count < COUNT_MAX)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
// On a cache miss, fetches the whole 8-word line from main memory, writes
// each returned word into the cache data array and, with the last word,
// writes the line's tag entry. Requests are issued back to back; responses
// may arrive with any latency (in order, at most one per cycle).
//   clk               : rising-edge clock
//   rst               : asynchronous active-high reset
//   miss_detected     : cache reports a miss this cycle
//   miss_address      : byte address of the missing access
//   memory_data       : word returned by main memory
//   memory_data_valid : memory_data valid this cycle
//   fsm_busy          : fill in progress (also high in the miss cycle)
//   memory_read_en    : issue a read of memory_address this cycle
//   memory_address    : word address requested from memory
//   cache_addr        : cache address (miss_address when idle, fill address)
//   data_out          : word to cache data_in
//   write_data_array  : cache data-array write enable
//   tag_out           : tag entry to cache tag_in
//   write_tag_array   : cache tag-array write enable
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic [15:0] memory_data,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        memory_read_en,
   output logic [15:0] memory_address,
   output logic [15:0] cache_addr,
   output logic [15:0] data_out,
   output logic        write_data_array,
   output logic [7:0]  tag_out,
   output logic        write_tag_array
);

   import cache_pkg::*;

   localparam logic [3:0] NUM_WORDS = 4'(BLOCK_WORDS);
   localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

   fill_state_t state;
   fill_state_t state_next;
   logic [15:4] base;
   logic [3:0]  req_cnt;
   logic [3:0]  rcv_cnt;
   logic        start_fill;

   // Request counter advances on every issued read; receive counter on
   // every word written. Both restart when a new miss is accepted.
   fill_counter #(.WIDTH(4), .MAX(BLOCK_WORDS)) u_req_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_fill),
      .enable (memory_read_en),
      .count  (req_cnt)
   );

   fill_counter #(.WIDTH(4), .MAX(BLOCK_WORDS)) u_rcv_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_fill),
      .enable (write_data_array),
      .count  (rcv_cnt)
   );

   // State register and line base. The base is only captured when a miss
   // is accepted from IDLE, so misses seen during a fill cannot disturb it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
      end else begin
         state <= state_next;
         if (start_fill) begin
            base <= miss_address[15:4];
         end
      end
   end

   // Next-state and outputs. Busy is raised combinationally in the miss
   // cycle so the pipeline stalls without a one-cycle hole. Memory
   // responses are only consumed in FILL; anything arriving in IDLE
   // (e.g. leftovers from a fill abandoned by reset) is dropped.
   always_comb begin
      state_next       = state;
      start_fill       = 1'b0;
      fsm_busy         = 1'b0;
      memory_read_en   = 1'b0;
      memory_address   = '0;
      cache_addr       = miss_address;
      data_out         = '0;
      write_data_array = 1'b0;
      tag_out          = '0;
      write_tag_array  = 1'b0;

      case (state)
         IDLE: begin
            if (miss_detected) begin
               fsm_busy   = 1'b1;
               start_fill = 1'b1;
               state_next = FILL;
            end
         end

         FILL: begin
            fsm_busy   = 1'b1;
            cache_addr = {base, rcv_cnt[2:0], 1'b0};

            if (req_cnt < NUM_WORDS) begin
               memory_read_en = 1'b1;
               memory_address = {base, req_cnt[2:0], 1'b0};
            end

            if (memory_data_valid) begin
               write_data_array = 1'b1;
               data_out         = memory_data;
               if (rcv_cnt == LAST_WORD) begin
                  write_tag_array = 1'b1;
                  tag_out         = make_tag(base[15:10]);
                  state_next      = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Scoreboard bench for cache_fill_fsm. Issuing a miss pushes the eight
// expected memory reads (with the cycle each must appear in) and the eight
// expected cache writes (address, data, tag on the last) into queues. A
// memory model answers reads after a programmable latency, optionally only
// on even cycles. A monitor on the falling edge pops and compares whenever
// the DUT presents a read or a write.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic [15:0] memory_data = '0;
   logic        memory_data_valid = 1'b0;
   logic        fsm_busy;
   logic        memory_read_en;
   logic [15:0] memory_address;
   logic [15:0] cache_addr;
   logic [15:0] data_out;
   logic        write_data_array;
   logic [7:0]  tag_out;
   logic        write_tag_array;

   cache_fill_fsm #(.BLOCK_WORDS(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data       (memory_data),
      .memory_data_valid (memory_data_valid),
      .fsm_busy          (fsm_busy),
      .memory_read_en    (memory_read_en),
      .memory_address    (memory_address),
      .cache_addr        (cache_addr),
      .data_out          (data_out),
      .write_data_array  (write_data_array),
      .tag_out           (tag_out),
      .write_tag_array   (write_tag_array)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] addr; int cyc; } rd_t;
   typedef struct { logic [15:0] addr; logic [15:0] data; logic last; logic [7:0] tag; } wr_t;
   typedef struct { logic [15:0] addr; int due; } pend_t;

   rd_t   rq[$];
   wr_t   wq[$];
   pend_t pq[$];

   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          lat      = 4;
   bit          bubble   = 1'b0;
   logic [15:0] salt     = '0;
   int          miss_cyc = 0;
   int          tag_cyc  = -1;
   logic [7:0]  last_tag = '0;

   // Cycle index, advanced on each rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ salt;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory model: answers each read 'lat' cycles later, in order, at most
   // one per cycle; in bubble mode only on even cycles.
   always @(posedge clk) begin
      #1;
      if (pq.size() > 0 && pq[0].due <= cyc && (!bubble || (cyc % 2 == 0))) begin
         memory_data_valid = 1'b1;
         memory_data       = mem_word(pq[0].addr);
         void'(pq.pop_front());
      end else begin
         memory_data_valid = 1'b0;
         memory_data       = 16'($urandom);
      end
   end

   // Monitor: compares the DUT against the queued expectations every cycle.
   rd_t mon_r;
   wr_t mon_w;
   int  wq_before;
   always @(negedge clk) begin
      wq_before = wq.size();
      check_output("busy", 32'(fsm_busy), 32'((wq_before > 0) || miss_detected));

      check_output("read_en", 32'(memory_read_en), 32'(rq.size() > 0 && rq[0].cyc == cyc));
      if (memory_read_en) begin
         pq.push_back('{memory_address, cyc + lat});
         if (rq.size() > 0) begin
            mon_r = rq.pop_front();
            check_output("read_addr", 32'(memory_address), 32'(mon_r.addr));
         end
      end else begin
         check_output("idle_read_addr", 32'(memory_address), 32'h0);
      end

      check_output("write_data", 32'(write_data_array), 32'(memory_data_valid && wq_before > 0 && !rst));
      if (write_data_array && wq_before > 0) begin
         mon_w = wq.pop_front();
         check_output("data_out", 32'(data_out), 32'(mon_w.data));
         check_output("fill_addr", 32'(cache_addr), 32'(mon_w.addr));
         check_output("write_tag", 32'(write_tag_array), 32'(mon_w.last));
         if (mon_w.last && write_tag_array) begin
            check_output("tag_out", 32'(tag_out), 32'(mon_w.tag));
            tag_cyc  = cyc;
            last_tag = tag_out;
         end
      end else begin
         check_output("stray_tag_write", 32'(write_tag_array), 32'h0);
      end

      if (wq_before == 0) begin
         check_output("idle_cache_addr", 32'(cache_addr), 32'(miss_address));
      end
   end

   // Queues what a correct fill of the line holding 'a' must produce.
   task automatic push_expect(input logic [15:0] a);
      logic [15:0] w;
      for (int i = 0; i < 8; i++) begin
         w = {a[15:4], 3'(i), 1'b0};
         rq.push_back('{w, cyc + 1 + i});
         wq.push_back('{w, w ^ salt, (i == 7), {a[15:10], 2'b10}});
      end
   endtask

   // Issues a miss (DUT must be idle) and runs the fill to completion.
   // With 'hold' the miss line stays high with random addresses.
   task automatic apply_stimulus(input logic [15:0] a, input bit hold);
      int budget;
      salt          = 16'($urandom);
      miss_cyc      = cyc;
      tag_cyc       = -1;
      miss_detected = 1'b1;
      miss_address  = a;
      push_expect(a);
      @(posedge clk); #1;
      budget = 300;
      while (wq.size() > 0 && budget > 0) begin
         miss_detected = hold;
         miss_address  = 16'($urandom);
         @(posedge clk); #1;
         budget--;
      end
      miss_detected = 1'b0;
      check_output("fill_done", 32'(wq.size()), 32'h0);
      if (!bubble) check_output("tag_cycle", 32'(tag_cyc - miss_cyc), 32'(8 + lat));
   endtask

   // Lets outstanding memory responses finish so the next fill starts clean.
   task automatic drain();
      int budget;
      budget = 100;
      while (pq.size() > 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check_output("drain", 32'(pq.size()), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [15:0] a;
      bit          hold;
      bit          b2b;

      rst           = 1'b1;
      miss_detected = 1'b0;
      miss_address  = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_busy", 32'(fsm_busy), 32'h0);
      check_output("reset_read_en", 32'(memory_read_en), 32'h0);
      check_output("reset_write", 32'(write_data_array), 32'h0);
      check_output("reset_tag_write", 32'(write_tag_array), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed miss 0x1A36, latency 4");
      lat = 4; bubble = 1'b0;
      apply_stimulus(16'h1A36, 1'b0);
      check_output("tag_1A36", 32'(last_tag), 32'h1A);
      drain();

      $display("[TB] latency 1");
      lat = 1;
      apply_stimulus(16'($urandom), 1'b0);
      drain();

      $display("[TB] bubbled responses");
      lat = 3; bubble = 1'b1;
      apply_stimulus(16'($urandom), 1'b0);
      drain();

      $display("[TB] miss held during fill");
      lat = 2; bubble = 1'b0;
      apply_stimulus(16'($urandom), 1'b1);
      drain();

      $display("[TB] reset in the middle of a fill");
      lat = 4;
      salt          = 16'($urandom);
      miss_cyc      = cyc;
      tag_cyc       = -1;
      miss_detected = 1'b1;
      miss_address  = 16'h5E72;
      push_expect(16'h5E72);
      @(posedge clk); #1;
      miss_detected = 1'b0;
      while (cyc < miss_cyc + 6) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      rq.delete();
      wq.delete();
      #1;
      check_output("rst_busy", 32'(fsm_busy), 32'h0);
      check_output("rst_read_en", 32'(memory_read_en), 32'h0);
      check_output("rst_write", 32'(write_data_array), 32'h0);
      check_output("rst_tag_write", 32'(write_tag_array), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      drain();
      check_output("no_tag_after_rst", 32'(tag_cyc), 32'hFFFF_FFFF);

      $display("[TB] back-to-back misses");
      lat = 4;
      apply_stimulus(16'h2468, 1'b0);
      apply_stimulus(16'hC0DE, 1'b0);
      drain();

      $display("[TB] randomized fills");
      for (int n = 0; n < 12; n++) begin
         lat    = int'($urandom_range(1, 6));
         bubble = 1'($urandom_range(0, 1));
         hold   = 1'($urandom_range(0, 1));
         b2b    = 1'($urandom_range(0, 1));
         a      = 16'($urandom);
         apply_stimulus(a, hold);
         if (!b2b) drain();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
